// File: rtl/long_op_scoreboard.sv
// long_op_scoreboard: tracks destination registers of long-latency ops
// (loads, mul/div) from issue in ID until their writeback, and raises a
// combinational ID stall for RAW/WAW on a pending register or when the
// outstanding-op limit is reached. Short-latency writes are left to the
// forwarding unit and never touch this block.
module long_op_scoreboard #(
   parameter int NREG    = 32,
   parameter int AW      = 5,
   parameter int MAX_OUT = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue_valid,
   input  logic                         issue_we,
   input  logic                         issue_long,
   input  logic [AW-1:0]                issue_rd,
   input  logic [AW-1:0]                rs1_id,
   input  logic [AW-1:0]                rs2_id,
   input  logic                         rs1_used,
   input  logic                         rs2_used,
   input  logic                         flush,
   input  logic                         wb_valid,
   input  logic                         wb_long,
   input  logic [AW-1:0]                wb_rd,
   output logic                         stall_id,
   output logic [NREG-1:0]              busy,
   output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
   output logic                         wb_err
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
   localparam logic [OW-1:0] ONE_C     = OW'(1);
   localparam logic [AW-1:0] X0_C      = {AW{1'b0}};

   logic [NREG-1:0] busy_r;
   logic [NREG-1:0] busy_nxt_s;
   logic [NREG-1:0] rel_mask_s;
   logic [NREG-1:0] pend_vec_s;
   logic [OW-1:0]   outstanding_r;
   logic [OW-1:0]   outstanding_nxt_s;
   logic            wb_err_r;
   logic            wb_rel_s;
   logic            wb_bad_s;
   logic            long_wr_s;
   logic            limit_s;
   logic            stall_s;
   logic            accept_s;

   // Classify the writeback: a matched long result releases its register,
   // an unmatched one (x0 or not pending) is flagged and otherwise ignored.
   always_comb begin
      wb_rel_s   = 1'b0;
      wb_bad_s   = 1'b0;
      rel_mask_s = {NREG{1'b0}};
      if (wb_valid && wb_long) begin
         if ((wb_rd != X0_C) && busy_r[wb_rd]) begin
            wb_rel_s           = 1'b1;
            rel_mask_s[wb_rd]  = 1'b1;
         end else begin
            wb_bad_s = 1'b1;
         end
      end else begin
         wb_rel_s = 1'b0;
      end
   end

   // Hazard check in ID: a register released by this cycle's writeback is
   // already covered by WB->ID forwarding, so it no longer counts as pending.
   always_comb begin
      pend_vec_s    = busy_r & ~rel_mask_s;
      pend_vec_s[0] = 1'b0;
      long_wr_s     = issue_we & issue_long & (issue_rd != X0_C);
      limit_s       = (outstanding_r == MAX_OUT_C) & ~wb_rel_s;
      stall_s       = issue_valid & ~flush &
                      ((rs1_used & pend_vec_s[rs1_id]) |
                       (rs2_used & pend_vec_s[rs2_id]) |
                       (issue_we & issue_long & pend_vec_s[issue_rd]) |
                       (long_wr_s & limit_s));
      accept_s      = issue_valid & ~flush & ~stall_s & long_wr_s;
   end

   // Next pending vector and count; a set on the register being released
   // in the same cycle wins, and the count then stays put.
   always_comb begin
      busy_nxt_s = busy_r & ~rel_mask_s;
      if (accept_s) begin
         busy_nxt_s[issue_rd] = 1'b1;
      end else begin
         busy_nxt_s[issue_rd] = busy_nxt_s[issue_rd];
      end
      busy_nxt_s[0] = 1'b0;
      case ({accept_s, wb_rel_s})
         2'b10:   outstanding_nxt_s = outstanding_r + ONE_C;
         2'b01:   outstanding_nxt_s = outstanding_r - ONE_C;
         default: outstanding_nxt_s = outstanding_r;
      endcase
   end

   // State registers with synchronous reset overriding issue and writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r        <= {NREG{1'b0}};
         outstanding_r <= {OW{1'b0}};
         wb_err_r      <= 1'b0;
      end else begin
         busy_r        <= busy_nxt_s;
         outstanding_r <= outstanding_nxt_s;
         wb_err_r      <= wb_bad_s;
      end
   end

   assign stall_id    = stall_s;
   assign busy        = busy_r;
   assign outstanding = outstanding_r;
   assign wb_err      = wb_err_r;

endmodule

// File: tb/tb_long_op_scoreboard.sv
// Self-checking bench for long_op_scoreboard: directed scenarios against
// constants plus a randomized run against a register-array reference model.
module tb_long_op_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_we, issue_long;
   logic [4:0]  issue_rd, rs1_id, rs2_id;
   logic        rs1_used, rs2_used, flush;
   logic        wb_valid, wb_long;
   logic [4:0]  wb_rd;
   logic        stall_id;
   logic [31:0] busy;
   logic [2:0]  outstanding;
   logic        wb_err;

   int n_pass  = 0;
   int n_total = 0;

   // reference model: which registers hold an unfinished long op
   bit m_busy[32];
   int m_cnt;
   bit m_err;

   long_op_scoreboard #(.NREG(32), .AW(5), .MAX_OUT(4)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_we(issue_we), .issue_long(issue_long),
      .issue_rd(issue_rd), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used(rs1_used), .rs2_used(rs2_used), .flush(flush),
      .wb_valid(wb_valid), .wb_long(wb_long), .wb_rd(wb_rd),
      .stall_id(stall_id), .busy(busy), .outstanding(outstanding), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   function automatic bit m_rel();
      return wb_valid && wb_long && (wb_rd != 0) && m_busy[wb_rd];
   endfunction

   function automatic bit m_pend(input int r);
      return (r != 0) && m_busy[r] && !(m_rel() && (int'(wb_rd) == r));
   endfunction

   function automatic bit m_stall();
      bit h;
      h = (rs1_used && m_pend(int'(rs1_id))) || (rs2_used && m_pend(int'(rs2_id)));
      if (issue_we && issue_long && m_pend(int'(issue_rd))) h = 1;
      if (issue_we && issue_long && issue_rd != 0 && m_cnt == 4 && !m_rel()) h = 1;
      return issue_valid && !flush && h;
   endfunction

   function automatic logic [31:0] m_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   // advance one clock and move the model along with the inputs held across it
   task automatic tick();
      bit rel, acc, err;
      rel = m_rel();
      acc = issue_valid && !flush && !m_stall() && issue_we && issue_long && issue_rd != 0;
      err = wb_valid && wb_long && (wb_rd == 0 || !m_busy[wb_rd]);
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 0;
         m_cnt = 0;
         m_err = 0;
      end else begin
         if (rel) m_busy[wb_rd] = 0;
         if (acc) m_busy[issue_rd] = 1;
         m_cnt = m_cnt + int'(acc) - int'(rel);
         m_err = err;
      end
   endtask

   task automatic idle();
      rst = 0; issue_valid = 0; issue_we = 0; issue_long = 0; issue_rd = 0;
      rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0; flush = 0;
      wb_valid = 0; wb_long = 0; wb_rd = 0;
   endtask

   task automatic issue_long_op(input logic [4:0] rd);
      issue_valid = 1; issue_we = 1; issue_long = 1; issue_rd = rd;
   endtask

   task automatic long_wb(input logic [4:0] rd);
      wb_valid = 1; wb_long = 1; wb_rd = rd;
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      tick();
      tick();
      rst = 0;
      n_total++; if (busy !== 32'h0) $display("FAIL reset_busy got %h want 0", busy); else n_pass++;
      n_total++; if (outstanding !== 3'd0) $display("FAIL reset_out got %0d want 0", outstanding); else n_pass++;
      n_total++; if (wb_err !== 1'b0) $display("FAIL reset_err got %b want 0", wb_err); else n_pass++;
      #1;
      n_total++; if (stall_id !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_id); else n_pass++;
   endtask

   task automatic test_load_raw();
      idle(); issue_long_op(5'd5); #1;
      n_total++; if (stall_id !== 1'b0) $display("FAIL load_issue_stall got %b want 0", stall_id); else n_pass++;
      tick();
      n_total++; if (busy !== 32'h20) $display("FAIL load_busy got %h want 00000020", busy); else n_pass++;
      n_total++; if (outstanding !== 3'd1) $display("FAIL load_out got %0d want 1", outstanding); else n_pass++;
      idle(); issue_valid = 1; rs1_id = 5; rs1_used = 1; #1;
      n_total++; if (stall_id !== 1'b1) $display("FAIL raw_stall1 got %b want 1", stall_id); else n_pass++;
      tick(); #1;
      n_total++; if (stall_id !== 1'b1) $display("FAIL raw_stall2 got %b want 1", stall_id); else n_pass++;
      long_wb(5'd5); #1;
      n_total++; if (stall_id !== 1'b0) $display("FAIL raw_wb_release got %b want 0", stall_id); else n_pass++;
      tick(); idle();
      n_total++; if (busy !== 32'h0) $display("FAIL raw_busy_after got %h want 0", busy); else n_pass++;
      n_total++; if (outstanding !== 3'd0) $display("FAIL raw_out_after got %0d want 0", outstanding); else n_pass++;
      n_total++; if (wb_err !== 1'b0) $display("FAIL raw_no_err got %b want 0", wb_err); else n_pass++;
   endtask

   task automatic test_x0();
      idle(); issue_long_op(5'd0); #1;
      n_total++; if (stall_id !== 1'b0) $display("FAIL x0_issue_stall got %b want 0", stall_id); else n_pass++;
      tick();
      n_total++; if (busy !== 32'h0) $display("FAIL x0_busy got %h want 0", busy); else n_pass++;
      n_total++; if (outstanding !== 3'd0) $display("FAIL x0_out got %0d want 0", outstanding); else n_pass++;
      idle(); issue_long_op(5'd3); tick();
      idle(); issue_valid = 1; rs1_used = 1; rs2_used = 1; rs1_id = 0; rs2_id = 0; #1;
      n_total++; if (stall_id !== 1'b0) $display("FAIL x0_read_stall got %b want 0", stall_id); else n_pass++;
      tick();
      n_total++; if (busy !== 32'h8) $display("FAIL x0_read_busy got %h want 00000008", busy); else n_pass++;
      idle(); long_wb(5'd3); tick(); idle();
   endtask

   task automatic test_limit();
      idle();
      for (int r = 1; r <= 4; r++) begin
         issue_long_op(5'(r)); #1;
         n_total++; if (stall_id !== 1'b0) $display("FAIL limit_fill_stall r=%0d got %b want 0", r, stall_id); else n_pass++;
         tick();
      end
      n_total++; if (outstanding !== 3'd4) $display("FAIL limit_full_out got %0d want 4", outstanding); else n_pass++;
      issue_long_op(5'd6); #1;
      n_total++; if (stall_id !== 1'b1) $display("FAIL limit_stall got %b want 1", stall_id); else n_pass++;
      tick();
      n_total++; if (busy !== 32'h1E) $display("FAIL limit_held_busy got %h want 0000001e", busy); else n_pass++;
      long_wb(5'd1); #1;
      n_total++; if (stall_id !== 1'b0) $display("FAIL limit_wb_stall got %b want 0", stall_id); else n_pass++;
      tick(); idle();
      n_total++; if (busy !== 32'h5C) $display("FAIL limit_swap_busy got %h want 0000005c", busy); else n_pass++;
      n_total++; if (outstanding !== 3'd4) $display("FAIL limit_swap_out got %0d want 4", outstanding); else n_pass++;
      long_wb(5'd2); tick(); long_wb(5'd3); tick(); long_wb(5'd4); tick(); long_wb(5'd6); tick();
      idle();
      n_total++; if (outstanding !== 3'd0) $display("FAIL limit_drain_out got %0d want 0", outstanding); else n_pass++;
   endtask

   task automatic test_waw();
      idle(); issue_long_op(5'd7); tick();
      issue_long_op(5'd7); #1;
      n_total++; if (stall_id !== 1'b1) $display("FAIL waw_stall got %b want 1", stall_id); else n_pass++;
      tick();
      n_total++; if (outstanding !== 3'd1) $display("FAIL waw_held_out got %0d want 1", outstanding); else n_pass++;
      long_wb(5'd7); #1;
      n_total++; if (stall_id !== 1'b0) $display("FAIL waw_wb_stall got %b want 0", stall_id); else n_pass++;
      tick(); idle();
      n_total++; if (busy !== 32'h80) $display("FAIL waw_set_wins got %h want 00000080", busy); else n_pass++;
      n_total++; if (outstanding !== 3'd1) $display("FAIL waw_out got %0d want 1", outstanding); else n_pass++;
      long_wb(5'd7); tick(); idle();
      n_total++; if (busy !== 32'h0) $display("FAIL waw_release got %h want 0", busy); else n_pass++;
   endtask

   task automatic test_wb_err();
      idle(); long_wb(5'd9); tick(); idle();
      n_total++; if (wb_err !== 1'b1) $display("FAIL err_pulse got %b want 1", wb_err); else n_pass++;
      n_total++; if (busy !== 32'h0) $display("FAIL err_busy got %h want 0", busy); else n_pass++;
      n_total++; if (outstanding !== 3'd0) $display("FAIL err_out got %0d want 0", outstanding); else n_pass++;
      tick();
      n_total++; if (wb_err !== 1'b0) $display("FAIL err_one_cycle got %b want 0", wb_err); else n_pass++;
      long_wb(5'd0); tick(); idle();
      n_total++; if (wb_err !== 1'b1) $display("FAIL err_x0 got %b want 1", wb_err); else n_pass++;
      wb_valid = 1; wb_long = 0; wb_rd = 5'd9; tick(); idle();
      n_total++; if (wb_err !== 1'b0) $display("FAIL err_short_wb got %b want 0", wb_err); else n_pass++;
   endtask

   task automatic test_flush_reset();
      idle(); issue_long_op(5'd5); tick();
      idle(); issue_long_op(5'd10); rs1_id = 5; rs1_used = 1; flush = 1; #1;
      n_total++; if (stall_id !== 1'b0) $display("FAIL flush_stall got %b want 0", stall_id); else n_pass++;
      tick();
      n_total++; if (busy !== 32'h20) $display("FAIL flush_no_set got %h want 00000020", busy); else n_pass++;
      flush = 0; #1;
      n_total++; if (stall_id !== 1'b1) $display("FAIL midreset_pre got %b want 1", stall_id); else n_pass++;
      rst = 1; tick(); idle();
      n_total++; if (busy !== 32'h0) $display("FAIL midreset_busy got %h want 0", busy); else n_pass++;
      n_total++; if (outstanding !== 3'd0) $display("FAIL midreset_out got %0d want 0", outstanding); else n_pass++;
      n_total++; if (wb_err !== 1'b0) $display("FAIL midreset_err got %b want 0", wb_err); else n_pass++;
      #1;
      n_total++; if (stall_id !== 1'b0) $display("FAIL midreset_stall got %b want 0", stall_id); else n_pass++;
   endtask

   task automatic test_random();
      bit exp_stall;
      for (int c = 0; c < 2000; c++) begin
         rst         = ($urandom_range(0, 199) == 0);
         issue_valid = ($urandom_range(0, 3) != 0);
         issue_we    = ($urandom_range(0, 3) != 0);
         issue_long  = ($urandom_range(0, 1) != 0);
         issue_rd    = 5'($urandom_range(0, 7));
         rs1_id      = 5'($urandom_range(0, 7));
         rs2_id      = 5'($urandom_range(0, 7));
         rs1_used    = ($urandom_range(0, 1) != 0);
         rs2_used    = ($urandom_range(0, 1) != 0);
         flush       = ($urandom_range(0, 9) == 0);
         wb_valid    = ($urandom_range(0, 9) < 4);
         wb_long     = ($urandom_range(0, 9) < 8);
         wb_rd       = 5'($urandom_range(0, 7));
         #1;
         exp_stall = m_stall();
         n_total++; if (stall_id !== exp_stall) $display("FAIL rnd_stall cyc=%0d got %b want %b", c, stall_id, exp_stall); else n_pass++;
         tick();
         n_total++; if (busy !== m_vec()) $display("FAIL rnd_busy cyc=%0d got %h want %h", c, busy, m_vec()); else n_pass++;
         n_total++; if (int'(outstanding) != m_cnt) $display("FAIL rnd_out cyc=%0d got %0d want %0d", c, outstanding, m_cnt); else n_pass++;
         n_total++; if (wb_err !== m_err) $display("FAIL rnd_err cyc=%0d got %b want %b", c, wb_err, m_err); else n_pass++;
      end
      idle();
   endtask

   initial begin
      idle();
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_cnt = 0;
      m_err = 0;
      test_reset();
      test_load_raw();
      test_x0();
      test_limit();
      test_waw();
      test_wb_err();
      test_flush_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
